// File: rtl/demux_reg_5_1.sv
// demux_reg_5_1: registered 1-to-5 write distributor.
// A one-deep pending stage takes a write over valid/ready. It then commits the
// write into one of five held destination registers, unless that destination
// is write-locked. An out-of-range select is dropped and latched as a sticky
// error.

// One destination: a held data register plus its one-cycle update strobe.
module demux_reg_5_1_lane #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             upd
);

  // Capture data on a commit to this lane; the strobe follows the commit 1:1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= OUT_RESET;
      upd <= 1'b0;
    end else begin
      upd <= wr;
      if (wr) q <= d;
    end
  end

endmodule

module demux_reg_5_1 #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic [4:0]       lock,
  input  logic             clr_err,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [4:0]       upd,
  output logic             err,
  output logic [2:0]       err_sel
);

  localparam int NUM_DST = 5;

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} pend_st_t;

  pend_st_t                        st;
  logic [2:0]                      pend_sel;
  logic [WIDTH-1:0]                pend_data;
  logic                            pend_valid;
  logic                            legal;
  logic                            locked;
  logic                            commit_now;
  logic                            accept;
  logic [7:0]                      lock_ext;
  logic [NUM_DST-1:0]              wr;
  logic [NUM_DST-1:0][WIDTH-1:0]   q;

  assign pend_valid = (st == HELD);
  assign legal      = (pend_sel <= 3'd4);
  // Zero-extend so illegal selects index a real bit; they read as unlocked.
  assign lock_ext   = {3'b000, lock};
  assign locked     = lock_ext[pend_sel];
  assign commit_now = pend_valid && !locked;
  // A pending write that commits this edge frees the slot for a new accept.
  assign in_ready   = rst_n && (!pend_valid || commit_now);
  assign accept     = in_valid && in_ready;

  // One-hot lane write enable for a legal, unlocked commit.
  always_comb begin
    wr = '0;
    if (commit_now && legal) wr = NUM_DST'(1) << pend_sel;
  end

  // Pending stage: refill on accept, drain on commit, hold while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= EMPTY;
      pend_sel  <= '0;
      pend_data <= '0;
    end else begin
      case (st)
        EMPTY: if (accept) st <= HELD;
        HELD:  if (commit_now && !accept) st <= EMPTY;
        default: st <= EMPTY;
      endcase
      if (accept) begin
        pend_sel  <= sel;
        pend_data <= din;
      end
    end
  end

  // Sticky error; a new illegal commit takes priority over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_sel <= '0;
    end else if (commit_now && !legal) begin
      err     <= 1'b1;
      err_sel <= pend_sel;
    end else if (clr_err) begin
      err     <= 1'b0;
      err_sel <= '0;
    end
  end

  for (genvar i = 0; i < NUM_DST; i++) begin : g_lane
    demux_reg_5_1_lane #(.WIDTH(WIDTH), .OUT_RESET(OUT_RESET)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[i]),
      .d     (pend_data),
      .q     (q[i]),
      .upd   (upd[i])
    );
  end

  assign o0 = q[0];
  assign o1 = q[1];
  assign o2 = q[2];
  assign o3 = q[3];
  assign o4 = q[4];

endmodule

// File: tb/tb_demux_reg_5_1.sv
// Directed bench for demux_reg_5_1 with hand-computed expectations.
module tb_demux_reg_5_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] din;
  logic [4:0] lock;
  logic       clr_err;
  logic [7:0] o0, o1, o2, o3, o4;
  logic [4:0] upd;
  logic       err;
  logic [2:0] err_sel;

  int total = 0;
  int bad   = 0;

  demux_reg_5_1 #(.WIDTH(8), .OUT_RESET(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .din      (din),
    .lock     (lock),
    .clr_err  (clr_err),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .upd      (upd),
    .err      (err),
    .err_sel  (err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp_upd;
    rst_n = 1'b0; in_valid = 1'b0; sel = '0; din = '0; lock = '0; clr_err = 1'b0;
    #1;
    chk("rst_o0", o0, 8'h00);
    chk("rst_upd", upd, 5'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdy", in_ready, 1'b0);

    // Reset while a write to o2 is pending.
    step(); rst_n = 1'b1;
    step();
    in_valid = 1'b1; sel = 3'd2; din = 8'hA5;
    chk("rdy_after_rel", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_o2", o2, 8'h00);
    chk("midrst_upd", upd, 5'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_rdy", in_ready, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("postrst_o2", o2, 8'h00);
    chk("postrst_upd", upd, 5'b0);

    // Stream one write to each destination.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sel = 3'(i); din = 8'(8'h11 * (i + 1));
      #1;
      chk("stream_rdy", in_ready, 1'b1);
      step();
      if (i > 0) begin
        exp_upd = 5'b1 << (i - 1);
        chk("stream_upd", upd, exp_upd);
      end
    end
    in_valid = 1'b0;
    step();
    chk("stream_upd4", upd, 5'b10000);
    chk("stream_o0", o0, 8'h11);
    chk("stream_o1", o1, 8'h22);
    chk("stream_o2", o2, 8'h33);
    chk("stream_o3", o3, 8'h44);
    chk("stream_o4", o4, 8'h55);
    step();
    chk("idle_upd", upd, 5'b0);

    // Lock stall on o2 with a second write queued behind it.
    lock = 5'b00100;
    in_valid = 1'b1; sel = 3'd2; din = 8'h7E;
    #1;
    chk("lock_acc_rdy", in_ready, 1'b1);
    step();
    sel = 3'd0; din = 8'h01;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("lock_rdy", in_ready, 1'b0);
      chk("lock_o2", o2, 8'h33);
      chk("lock_upd", upd, 5'b0);
      step();
    end
    lock = 5'b0;
    #1;
    chk("unlock_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("unlock_o2", o2, 8'h7E);
    chk("unlock_upd2", upd, 5'b00100);
    step();
    chk("unlock_o0", o0, 8'h01);
    chk("unlock_upd0", upd, 5'b00001);

    // Illegal select is dropped and flagged.
    in_valid = 1'b1; sel = 3'b110; din = 8'hFF;
    step();
    in_valid = 1'b0;
    step();
    chk("ill_upd", upd, 5'b0);
    chk("ill_err", err, 1'b1);
    chk("ill_err_sel", err_sel, 3'b110);
    chk("ill_o", {o4, o3, o2, o1, o0}, 40'h55_44_7E_22_01);
    in_valid = 1'b1; sel = 3'd1; din = 8'h9C;
    step();
    in_valid = 1'b0;
    step();
    chk("ill_next_o1", o1, 8'h9C);
    chk("ill_next_upd", upd, 5'b00010);
    chk("ill_next_err", err, 1'b1);

    // clr_err collides with an illegal commit: the new error wins.
    in_valid = 1'b1; sel = 3'b111; din = 8'h00;
    step();
    in_valid = 1'b0; clr_err = 1'b1;
    step();
    chk("coll_err", err, 1'b1);
    chk("coll_err_sel", err_sel, 3'b111);
    step();
    clr_err = 1'b0;
    chk("clr_err", err, 1'b0);
    chk("clr_err_sel", err_sel, 3'b000);

    // Back-to-back writes to o4.
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; sel = 3'd4; din = 8'(i);
      step();
      if (i > 1) begin
        chk("b2b_upd", upd, 5'b10000);
        chk("b2b_o4", o4, 32'(i - 1));
      end
    end
    in_valid = 1'b0;
    step();
    chk("b2b_upd_last", upd, 5'b10000);
    chk("b2b_o4_last", o4, 8'h03);
    step();
    chk("b2b_upd_idle", upd, 5'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_reg_5_1.md
# demux_reg_5_1

Registered 1-to-5 write distributor for the accumulator datapath. One 8-bit result from the ALU or accumulator is accepted over a valid/ready handshake and committed into one of five held destination registers. Each destination can be write-locked, which stalls the pending write. An out-of-range select is discarded and flagged. The block is the write-side counterpart of the 5:1 operand select: the mux picks one of five sources to read, and this block picks one of five destinations to write.

## Interface
- WIDTH, 8, data width of din and of each destination register
- OUT_RESET, 8'h00, reset value of o0..o4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  write request present
- in_ready  output  1  block can accept a write this cycle
- sel  input  3  destination select: 000→o0, 001→o1, 010→o2, 011→o3, 100→o4; 101–111 illegal
- din  input  WIDTH  write data
- lock  input  5  per-destination write lock; lock[i]=1 blocks commits to o_i
- clr_err  input  1  synchronous clear of err and err_sel
- o0, o1, o2, o3, o4  output  WIDTH each  held destination registers
- upd  output  5  one-cycle strobe; upd[i] marks that o_i was written at the preceding edge
- err  output  1  sticky flag: an illegal select was accepted
- err_sel  output  3  select value of the most recent illegal write

## Operation
- **Reset values (asynchronous, rst_n low):**
  - o0..o4 = OUT_RESET; upd = 0; err = 0; err_sel = 0.
  - The pending register is emptied (pend_valid = 0).
  - in_ready is forced to 0 while rst_n is low.
- **Pending stage:** a one-deep buffer holding pend_valid, pend_sel and pend_data.
- **Accept:** a write is accepted when in_valid && in_ready at a rising edge. On accept, pend_sel <= sel, pend_data <= din and pend_valid <= 1.
- **Commit condition:** commit_now = pend_valid && (pend_sel > 4 || lock[pend_sel] == 0). lock is sampled in the cycle the commit is evaluated.
- **Flow control:** in_ready = rst_n && (!pend_valid || commit_now). This gives combinational pass-through, so a commit and a new accept can occur at the same edge.
- **Legal commit** (pend_sel ≤ 4, unlocked):
  - o[pend_sel] <= pend_data.
  - upd[pend_sel] <= 1 and all other upd bits <= 0.
  - Other outputs hold their values.
- **Illegal commit** (pend_sel 5–7):
  - No output register changes and upd <= 0.
  - err <= 1 and err_sel <= pend_sel.
  - Lock is ignored.
- **Locked pending write:**
  - pend_valid stays 1 and the pending data is held.
  - in_ready = 0 and upd <= 0.
  - The commit happens at the first edge where lock[pend_sel] == 0.
- **upd when idle:** upd <= 0 on any edge without a commit. upd is never multi-hot.
- **clr_err:** clears err and err_sel at the next edge. If an illegal commit occurs at the same edge, the new error wins: err = 1 and err_sel is updated.
- **Outputs hold value indefinitely** between commits. Locks never alter stored values.
- **No internal state machine beyond the pending stage.** There are two states:
  - EMPTY (pend_valid = 0).
  - HELD (pend_valid = 1), which stays HELD while locked, or on a commit with a simultaneous new accept.

## Timing
- A write accepted at edge k commits at edge k+1 if unlocked. From edge k+1:
  - o_i shows the new data.
  - upd[i] is high for exactly the cycle between edges k+1 and k+2.
- Sustained throughput is one write per cycle when the targets are unlocked.
- A lock asserted in the commit cycle delays the commit. Each locked cycle adds one cycle of latency.
- Back-to-back writes to the same destination: upd[i] stays high for consecutive cycles, and o_i steps through each value.
- rst_n asserted mid-operation: the pending write is discarded and never committed, and all outputs return to reset values immediately (asynchronously).
- Release of rst_n is synchronised externally. The first accept is possible at the first edge after release.

## Test plan
- **Reset:** drive rst_n low mid-pending with pend_sel=2, din=8'hA5. Required: o0..o4 = 8'h00, upd = 0, err = 0, in_ready = 0; after release, o2 is still 8'h00.
- **Streaming:** stream sel = 0,1,2,3,4 with din = 8'h11,22,33,44,55 on consecutive cycles, all unlocked. Required: in_ready stays 1; upd = 00001, 00010, 00100, 01000, 10000 on the five cycles after each accept; final o0..o4 = 11, 22, 33, 44, 55.
- **Lock stall:** set lock = 5'b00100 and write sel=2, din=8'h7E, then hold in_valid with sel=0, din=8'h01. Required: in_ready = 0 for 3 cycles while o2 holds its old value; release lock; then o2 = 7E with upd = 00100, followed one cycle later by o0 = 01 with upd = 00001.
- **Illegal select:** write sel=3'b110, din=8'hFF. Required: no o_i changes, upd = 0, err = 1, err_sel = 110. A later legal write to sel=1 succeeds while err stays 1.
- **clr_err collision:** assert clr_err in the same cycle as an illegal commit with sel=3'b111. Required: err = 1 and err_sel = 111. clr_err alone on the next cycle gives err = 0 and err_sel = 000.
- **Same-destination back-to-back:** write sel=4 three times with din = 8'h01, 02, 03. Required: upd[4] is high for 3 consecutive cycles; o4 sequence is 01, 02, 03.
